uart_tx_frame_engine: RTL and testbench
=======================================

Name: uart_tx_frame_engine

Overview:
- UART transmitter: serialises one parallel byte into a start/data/parity/stop frame on `tx_out`.
- Timing is the same oversampled scheme as the receive path, with one bit lasting `prescale` clock cycles.
- Sits opposite the UART RX block. It shares the TX/RX clock domain and the prescale/parity configuration registers, so a loopback of `tx_out` into RX reproduces the byte.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, sent LSB first.
- PRESCALE_WIDTH, 6, width of the `prescale` input and the internal edge counter.

Ports:
- CLK_EDGE  in  1  oversampling clock (baud x prescale).
- RST_EDGE  in  1  reset; asynchronous, active-low.
- data_valid  in  1  request to send `p_data`; sampled only when `busy`=0.
- p_data  in  DATA_WIDTH  byte to transmit.
- par_en  in  1  1 = insert parity bit.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- prescale  in  PRESCALE_WIDTH  clock cycles per bit; supported values 8, 16, 32.
- tx_out  out  1  serial line; idle high.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset values: `tx_out`=1, `busy`=0, `frame_done`=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately: line returns to 1 and nothing resumes after release.
- All outputs are registered.
- Accept: at a rising edge where `busy`=0 and `data_valid`=1, the following are captured into holding registers:
  - `p_data`, `par_en`, `par_typ` and `prescale`.
  - Parity, computed as XOR-reduce(`p_data`) XOR `par_typ`.
- After accept, input changes have no effect on the current frame.
- Latency from accept to line activity: `tx_out`=0 and `busy`=1 become visible in the cycle following the accepting edge (zero extra latency).
- FSM states: IDLE -> START -> DATA -> (PARITY if `par_en`) -> STOP -> IDLE.
- Bit timing: each state holds its line value for exactly P cycles, P = captured `prescale`.
  - The edge counter runs 0..P-1 and wraps to 0 at P-1.
  - On wrap the bit counter increments and the FSM advances.
- DATA state:
  - Bit counter selects `p_data`[bit_cnt], LSB first.
  - DATA exits after DATA_WIDTH wraps.
  - The bit counter clears on every state change.
- PARITY state drives the captured parity bit for P cycles.
- STOP state:
  - Drives 1 for P cycles.
  - `frame_done`=1 during cycle P-1 of STOP.
  - At that wrap the FSM goes to IDLE and `busy` goes 0 in the next cycle.
- Frame length: `busy` high for exactly P x (2 + DATA_WIDTH + `par_en`) cycles.
- Back-to-back frames: `data_valid` held high gives one idle cycle (`busy`=0, `tx_out`=1) between the stop bit and the next start bit.
- A `data_valid` asserted while `busy`=1 is ignored: no queue, no error flag.
- Illegal prescale: a captured `prescale` of 0 or 1 is treated as 2. Other values are honoured as given; no range check.
- Widths: counters are PRESCALE_WIDTH and clog2(DATA_WIDTH+1) bits; no wrap beyond their terminal counts.

Decomposition:
- Shared package `uart_pkg` holds:
  - The TX FSM state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - Parity-type constants (PAR_EVEN=0, PAR_ODD=1).
  - Default DATA_WIDTH and PRESCALE_WIDTH.
- One sub-module, `tx_edge_bit_counter`:
  - Inputs: enable, clear-on-state-change, P.
  - Outputs: `edge_cnt`, `bit_cnt`, and a `bit_wrap` strobe.
  - Mirrors the RX counter with a terminal-count strobe added.
- The top module holds the FSM, holding registers, parity and the output mux.

Test Plan:
- P=8, `par_en`=0, `p_data`=0xA5 -> `tx_out` sequence 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; `busy` high for 80 cycles; `frame_done` pulses once, at cycle 79.
- P=16, `par_en`=1, `par_typ`=0, `p_data`=0x07 -> parity bit = 1; frame 11 bits = 176 cycles.
  - Same data with `par_typ`=1 -> parity bit = 0.
- Back-to-back: `data_valid` held high with 0x55 then 0xAA, P=8 -> second start bit begins exactly 1 idle cycle after the first stop bit ends; both bytes are received correctly by the RX block in loopback.
- Busy drop: `data_valid` pulsed with 0x3C during the DATA state of a 0x81 frame -> only 0x81 is transmitted, and the line stays idle afterwards.
- Input change after accept: `p_data`/`prescale` changed 1 cycle after accept (0x12 -> 0xFF, 8 -> 32) -> frame still carries 0x12 at 8 cycles/bit.
- Reset mid-frame: `RST_EDGE` low during bit 3 of DATA -> `tx_out`=1 and `busy`=0 asynchronously; after release the line stays idle until a new `data_valid`, then a correct full frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM encoding, parity types and default widths.
package uart_pkg;

   localparam int DATA_WIDTH_DEF     = 8;
   localparam int PRESCALE_WIDTH_DEF = 6;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/tx_edge_bit_counter.sv
// Per-bit edge counter (0..P-1) with a bit counter that advances on each wrap.
module tx_edge_bit_counter #(
   parameter int PRESCALE_WIDTH = 6,
   parameter int BIT_CNT_WIDTH  = 4,
   parameter int MAX_BITS       = 8
) (
   input  logic                      CLK_EDGE,
   input  logic                      RST_EDGE,
   input  logic                      en_i,
   input  logic                      clr_i,
   input  logic [PRESCALE_WIDTH-1:0] p_i,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt_o,
   output logic [BIT_CNT_WIDTH-1:0]  bit_cnt_o,
   output logic                      bit_wrap_o
);

   localparam logic [BIT_CNT_WIDTH-1:0] BIT_MAX = BIT_CNT_WIDTH'(MAX_BITS);

   logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
   logic                      wrap;

   always_comb begin
      wrap       = en_i && (edge_cnt_q == (p_i - PRESCALE_WIDTH'(1)));
      edge_cnt_d = edge_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      if (clr_i) begin
         edge_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (en_i) begin
         edge_cnt_d = wrap ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
         // saturate rather than roll over past the last data bit
         if (wrap && (bit_cnt_q != BIT_MAX))
            bit_cnt_d = bit_cnt_q + BIT_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK_EDGE or negedge RST_EDGE) begin
      if (!RST_EDGE) begin
         edge_cnt_q <= '0;
         bit_cnt_q  <= '0;
      end else begin
         edge_cnt_q <= edge_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign edge_cnt_o = edge_cnt_q;
   assign bit_cnt_o  = bit_cnt_q;
   assign bit_wrap_o = wrap;

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; P clocks per bit.
//
//   state  | meaning
//   IDLE   | line high, waiting for data_valid
//   START  | drive 0 for P cycles
//   DATA   | drive data bit bit_cnt for P cycles, DATA_WIDTH bits
//   PARITY | drive captured parity bit for P cycles (only if par_en)
//   STOP   | drive 1 for P cycles, frame_done on the last cycle
module uart_tx_frame_engine
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
   input  logic                      CLK_EDGE,
   input  logic                      RST_EDGE,
   input  logic                      data_valid,
   input  logic [DATA_WIDTH-1:0]     p_data,
   input  logic                      par_en,
   input  logic                      par_typ,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tx_out,
   output logic                      busy,
   output logic                      frame_done
);

   localparam int BCW = $clog2(DATA_WIDTH + 1);

   tx_state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      par_en_q, par_bit_q;
   logic [PRESCALE_WIDTH-1:0] p_q, p_eff;
   logic                      tx_out_q, tx_out_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      accept;

   logic [PRESCALE_WIDTH-1:0] edge_cnt;
   logic [BCW-1:0]            bit_cnt;
   logic                      bit_wrap;
   logic [DATA_WIDTH-1:0]     cur_sh, nxt_sh;

   assign accept = (state_q == IDLE) && !busy_q && data_valid;
   assign p_eff  = (prescale < PRESCALE_WIDTH'(2)) ? PRESCALE_WIDTH'(2) : prescale;

   tx_edge_bit_counter #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .BIT_CNT_WIDTH  (BCW),
      .MAX_BITS       (DATA_WIDTH)
   ) u_cnt (
      .CLK_EDGE   (CLK_EDGE),
      .RST_EDGE   (RST_EDGE),
      .en_i       (state_q != IDLE),
      .clr_i      (state_d != state_q),
      .p_i        (p_q),
      .edge_cnt_o (edge_cnt),
      .bit_cnt_o  (bit_cnt),
      .bit_wrap_o (bit_wrap)
   );

   // Outputs are registered, so each branch drives the value for the next state.
   always_comb begin
      state_d  = state_q;
      tx_out_d = 1'b1;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      cur_sh   = data_q >> bit_cnt;
      nxt_sh   = data_q >> (bit_cnt + BCW'(1));
      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (accept) begin
               state_d  = START;
               tx_out_d = 1'b0;
               busy_d   = 1'b1;
            end
         end
         START: begin
            tx_out_d = 1'b0;
            if (bit_wrap) begin
               state_d  = DATA;
               tx_out_d = data_q[0];
            end
         end
         DATA: begin
            tx_out_d = cur_sh[0];
            if (bit_wrap) begin
               if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                  state_d  = par_en_q ? PARITY : STOP;
                  tx_out_d = par_en_q ? par_bit_q : 1'b1;
               end else begin
                  tx_out_d = nxt_sh[0];
               end
            end
         end
         PARITY: begin
            tx_out_d = par_bit_q;
            if (bit_wrap) begin
               state_d  = STOP;
               tx_out_d = 1'b1;
            end
         end
         STOP: begin
            done_d = !bit_wrap && (edge_cnt == (p_q - PRESCALE_WIDTH'(2)));
            if (bit_wrap) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK_EDGE or negedge RST_EDGE) begin
      if (!RST_EDGE) begin
         state_q   <= IDLE;
         tx_out_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         p_q       <= '0;
      end else begin
         state_q  <= state_d;
         tx_out_q <= tx_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         if (accept) begin
            data_q    <= p_data;
            par_en_q  <= par_en;
            par_bit_q <= (^p_data) ^ par_typ;
            p_q       <= p_eff;
         end
      end
   end

   assign tx_out     = tx_out_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Directed bench for uart_tx_frame_engine: frame shape, timing, parity, back-to-back, reset.
module tb_uart_tx_frame_engine;

   logic       clk_edge = 1'b0;
   logic       rst_edge = 1'b0;
   logic       data_valid = 1'b0;
   logic [7:0] p_data = 8'h00;
   logic       par_en = 1'b0;
   logic       par_typ = 1'b0;
   logic [5:0] prescale = 6'd8;
   logic       tx_out, busy, frame_done;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_edge = ~clk_edge;

   uart_tx_frame_engine #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
      .CLK_EDGE   (clk_edge),
      .RST_EDGE   (rst_edge),
      .data_valid (data_valid),
      .p_data     (p_data),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .prescale   (prescale),
      .tx_out     (tx_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic model_bit(input logic [7:0] d, input logic pen, input logic ptyp, input int k);
      if (k == 0) return 1'b0;
      if (k >= 1 && k <= 8) return d[k-1];
      if (k == 9 && pen) return (^d) ^ ptyp;
      return 1'b1;
   endfunction

   // Drive a request at a falling edge; returns at cycle 0 of the frame with data_valid still high.
   task automatic request(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] p);
      @(negedge clk_edge);
      p_data = d; par_en = pen; par_typ = ptyp; prescale = p;
      data_valid = 1'b1;
      @(negedge clk_edge);
   endtask

   // Called at cycle 0 of a frame; samples each falling edge until busy drops.
   task automatic watch_frame(input string tag, input logic [7:0] d, input logic pen,
                              input logic ptyp, input int p,
                              output logic [7:0] rx_byte, output logic par_seen);
      int cyc = 0, errs = 0, done_cnt = 0, done_at = -1;
      int exp_len = p * (10 + int'(pen));
      rx_byte = 8'h00;
      par_seen = 1'b0;
      while (busy === 1'b1 && cyc < 2000) begin
         if (tx_out !== model_bit(d, pen, ptyp, cyc / p)) errs++;
         if (frame_done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
         end
         if ((cyc % p) == (p / 2)) begin
            if (cyc / p >= 1 && cyc / p <= 8) rx_byte[cyc / p - 1] = tx_out;
            if (cyc / p == 9) par_seen = tx_out;
         end
         cyc++;
         @(negedge clk_edge);
      end
      chk({tag, "_len"}, cyc, exp_len);
      chk({tag, "_line_errs"}, errs, 0);
      chk({tag, "_done_cnt"}, done_cnt, 1);
      chk({tag, "_done_at"}, done_at, exp_len - 1);
      chk({tag, "_idle_tx"}, tx_out, 1'b1);
   endtask

   logic [7:0] rx;
   logic       par;
   int         stray;

   initial begin
      // reset
      repeat (3) @(negedge clk_edge);
      chk("rst_tx", tx_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", frame_done, 1'b0);
      rst_edge = 1'b1;
      repeat (2) @(negedge clk_edge);
      chk("post_rst_busy", busy, 1'b0);

      // 0xA5, P=8, no parity: 0,1,0,1,0,0,1,0,1,1
      request(8'hA5, 1'b0, 1'b0, 6'd8);
      data_valid = 1'b0;
      chk("a5_start_tx", tx_out, 1'b0);
      chk("a5_start_busy", busy, 1'b1);
      watch_frame("a5", 8'hA5, 1'b0, 1'b0, 8, rx, par);
      chk("a5_rx", rx, 8'hA5);

      // 0x07, P=16, even parity -> parity bit 1
      request(8'h07, 1'b1, 1'b0, 6'd16);
      data_valid = 1'b0;
      watch_frame("p07e", 8'h07, 1'b1, 1'b0, 16, rx, par);
      chk("p07e_par", par, 1'b1);
      chk("p07e_rx", rx, 8'h07);

      // same data, odd parity -> parity bit 0
      request(8'h07, 1'b1, 1'b1, 6'd16);
      data_valid = 1'b0;
      watch_frame("p07o", 8'h07, 1'b1, 1'b1, 16, rx, par);
      chk("p07o_par", par, 1'b0);

      // back-to-back 0x55 then 0xAA with data_valid held
      request(8'h55, 1'b0, 1'b0, 6'd8);
      p_data = 8'hAA;
      watch_frame("b2b1", 8'h55, 1'b0, 1'b0, 8, rx, par);
      chk("b2b1_rx", rx, 8'h55);
      chk("b2b_gap_busy", busy, 1'b0);
      @(negedge clk_edge);
      data_valid = 1'b0;
      chk("b2b2_start_busy", busy, 1'b1);
      watch_frame("b2b2", 8'hAA, 1'b0, 1'b0, 8, rx, par);
      chk("b2b2_rx", rx, 8'hAA);

      // request during DATA of a 0x81 frame is dropped
      request(8'h81, 1'b0, 1'b0, 6'd8);
      data_valid = 1'b0;
      fork
         watch_frame("drop", 8'h81, 1'b0, 1'b0, 8, rx, par);
         begin
            repeat (30) @(negedge clk_edge);
            p_data = 8'h3C;
            data_valid = 1'b1;
            @(negedge clk_edge);
            data_valid = 1'b0;
         end
      join
      chk("drop_rx", rx, 8'h81);
      stray = 0;
      repeat (40) begin
         @(negedge clk_edge);
         if (busy !== 1'b0 || tx_out !== 1'b1) stray++;
      end
      chk("drop_idle_after", stray, 0);

      // inputs changed one cycle after accept
      request(8'h12, 1'b0, 1'b0, 6'd8);
      data_valid = 1'b0;
      p_data = 8'hFF;
      prescale = 6'd32;
      watch_frame("hold", 8'h12, 1'b0, 1'b0, 8, rx, par);
      chk("hold_rx", rx, 8'h12);

      // illegal prescale 1 is treated as 2
      request(8'h3C, 1'b0, 1'b0, 6'd1);
      data_valid = 1'b0;
      watch_frame("p1", 8'h3C, 1'b0, 1'b0, 2, rx, par);

      // reset during data bit 3 (cycles 32..39 at P=8)
      request(8'h5A, 1'b0, 1'b0, 6'd8);
      data_valid = 1'b0;
      repeat (35) @(negedge clk_edge);
      chk("pre_rst_busy", busy, 1'b1);
      #2 rst_edge = 1'b0;
      #1;
      chk("async_rst_tx", tx_out, 1'b1);
      chk("async_rst_busy", busy, 1'b0);
      repeat (2) @(negedge clk_edge);
      rst_edge = 1'b1;
      stray = 0;
      repeat (20) begin
         @(negedge clk_edge);
         if (busy !== 1'b0 || tx_out !== 1'b1) stray++;
      end
      chk("rst_idle_after", stray, 0);

      // full frame after recovery, P=32, odd parity: ^C3=0 -> parity 1
      request(8'hC3, 1'b1, 1'b1, 6'd32);
      data_valid = 1'b0;
      watch_frame("rec", 8'hC3, 1'b1, 1'b1, 32, rx, par);
      chk("rec_rx", rx, 8'hC3);
      chk("rec_par", par, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
